// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: byte-serial little-endian load/store with pipeline stall
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_rd_data,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_rd_enable,
  input  logic [3:0]        ex_mem_op,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic [REG_AW-1:0] mem_rd_addr,
  output logic              mem_rd_enable,
  output logic              stall_req
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t state, state_nxt;

  // Latched instruction; ex_* is ignored once an access has been accepted
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] sdata_q;
  logic [REG_AW-1:0] rd_addr_q;
  logic              rd_en_q;
  logic [1:0]        idx;
  logic [31:0]       rbuf;

  logic              op_valid;
  logic              op_store;
  logic [1:0]        last_idx;
  logic [DATA_W-1:0] load_val;

  // Decode incoming op validity, latched op type and access length
  always_comb begin
    op_valid = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_SW);
    op_store = (op_q >= OP_SB) && (op_q <= OP_SW);
    case (op_q)
      OP_LB, OP_LBU, OP_SB: last_idx = 2'd0;
      OP_LH, OP_LHU, OP_SH: last_idx = 2'd1;
      default:              last_idx = 2'd3;
    endcase
  end

  // Extend the assembled read buffer to register width according to the load type
  always_comb begin
    case (op_q)
      OP_LB:   load_val = DATA_W'($signed(rbuf[7:0]));
      OP_LH:   load_val = DATA_W'($signed(rbuf[15:0]));
      OP_LBU:  load_val = DATA_W'(rbuf[7:0]);
      OP_LHU:  load_val = DATA_W'(rbuf[15:0]);
      default: load_val = DATA_W'(rbuf);
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE always returns to IDLE so the held ex_* op cannot retrigger
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_valid) state_nxt = XFER;
      XFER:    if (mem_ready && (idx == last_idx)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction latch, byte index and read buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      base_q    <= '0;
      sdata_q   <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      idx       <= '0;
      rbuf      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            op_q      <= ex_mem_op;
            base_q    <= ex_mem_addr;
            sdata_q   <= ex_store_data;
            rd_addr_q <= ex_rd_addr;
            rd_en_q   <= ex_rd_enable;
            idx       <= '0;
            rbuf      <= '0;
          end
        end
        XFER: begin
          if (mem_ready) begin
            if (!op_store) rbuf[{idx, 3'b000} +: 8] <= mem_rdata;
            if (idx != last_idx) idx <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode per state; memory port is quiet outside XFER
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_rd_data   = '0;
    mem_rd_addr   = '0;
    mem_rd_enable = 1'b0;
    stall_req     = 1'b0;
    case (state)
      IDLE: begin
        mem_rd_data   = ex_rd_data;
        mem_rd_addr   = ex_rd_addr;
        mem_rd_enable = op_valid ? 1'b0 : ex_rd_enable;
        stall_req     = op_valid;
      end
      XFER: begin
        mem_req   = 1'b1;
        mem_we    = op_store;
        mem_addr  = base_q + ADDR_W'(idx);
        mem_wdata = sdata_q[{idx, 3'b000} +: 8];
        stall_req = 1'b1;
      end
      DONE: begin
        mem_rd_addr = rd_addr_q;
        if (!op_store) begin
          mem_rd_data   = load_val;
          mem_rd_enable = rd_en_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage RISC-V pipeline; sits between ex_mem and mem_wb.
- Executes loads and stores over a byte-serial memory-controller port, one byte per transfer, little-endian.
- Holds the pipeline via stall_req until the access completes.
- Passes ALU results through unchanged for non-memory instructions.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, register width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ex_rd_data  in  DATA_W  ALU result (non-memory ops)
- ex_rd_addr  in  REG_AW  destination register
- ex_rd_enable  in  1  writeback enable
- ex_mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- ex_mem_addr  in  ADDR_W  effective address
- ex_store_data  in  DATA_W  store value (rs2)
- mem_req  out  1  byte transfer request
- mem_we  out  1  1 = write byte
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_ready  in  1  current byte transfer completes this cycle
- mem_rdata  in  8  read byte, valid when mem_ready=1
- mem_rd_data  out  DATA_W  to mem_wb
- mem_rd_addr  out  REG_AW  to mem_wb
- mem_rd_enable  out  1  to mem_wb
- stall_req  out  1  to ctrl; requests a stall of stages 0-4

Behaviour:
- Access length: 1 for B/BU, 2 for H/HU, 4 for W.
  - No alignment check.
  - The address increments per byte and wraps modulo 2^ADDR_W.
- State machine has three states: IDLE, XFER, DONE.
- IDLE:
  - If ex_mem_op is NONE, outputs pass through combinationally (mem_rd_* = ex_rd_*) and stall_req=0.
  - If ex_mem_op is a valid load/store:
    - stall_req=1 and mem_rd_enable=0 combinationally.
    - Latch op, addr, store data, rd_addr, rd_enable.
    - Set idx=0 and clear the read buffer; next state XFER.
- XFER:
  - Outputs: mem_req=1, mem_we=(op is store), mem_addr=base+idx, mem_wdata=store_data[8*idx+7:8*idx].
  - stall_req=1, mem_rd_enable=0.
  - On mem_ready=1:
    - For loads, buf[8*idx+7:8*idx] <= mem_rdata.
    - If idx==len-1, go to DONE; otherwise idx<=idx+1.
  - On mem_ready=0, hold all outputs stable.
- DONE:
  - stall_req=0 and mem_req=0; next state is IDLE unconditionally.
  - Loads:
    - mem_rd_data = buf extended to DATA_W: sign-extended for LB/LH, zero-extended for LBU/LHU, whole buffer for LW.
    - mem_rd_addr/mem_rd_enable come from the latched values.
  - Stores: mem_rd_enable=0, mem_rd_data=0.
  - ex_* still holds the same instruction in this cycle and must NOT retrigger an access; IDLE samples the next instruction.
- Latency: a memory op occupies 2+N cycles minimum (N = length), plus 1 cycle per mem_ready=0 wait. NONE ops add 0 cycles.
- When not in XFER: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset:
  - Effective on the clk edge with rst=1: state<=IDLE, idx<=0, buffer<=0, all latches<=0.
  - After reset, mem_req=0, mem_we=0, stall_req=0, mem_rd_enable=0 (given ex_mem_op=NONE).
  - Reset mid-XFER aborts the access; bytes already written stay written.
  - A mem_ready arriving in the same cycle as rst is ignored.
- Simultaneous events:
  - mem_ready=1 on the last byte moves to DONE.
  - A new ex_* op during XFER/DONE is ignored, since the pipeline is stalled and the latched values are used.
  - Writes to x0 are not suppressed here; register.v handles x0.

Test Plan:
1. ADD passthrough: op=0, ex_rd_data=0x12345678, rd_addr=5, en=1 -> same cycle mem_rd_data=0x12345678, mem_rd_addr=5, mem_rd_enable=1, stall_req=0, mem_req=0.
2. LW at 0x100, memory bytes 0x78,0x56,0x34,0x12, mem_ready=1 every XFER cycle, rd_addr=3:
   - mem_addr sequence is 0x100..0x103.
   - stall_req=1 for 5 cycles, then DONE shows mem_rd_data=0x12345678, rd_addr=3, en=1.
   - Next cycle is IDLE.
3. LB and LBU at 0x200 returning 0x80 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH/LHU of 0x8001 give 0xFFFF8001 and 0x00008001.
4. SW 0xDEADBEEF at 0x300, mem_ready low for 2 cycles on byte 1:
   - mem_we=1 with wdata sequence EF,BE,BE,BE,AD,DE at addrs 300,301,301,301,302,303.
   - In DONE, mem_rd_enable=0 and stall_req drops.
5. Wrap: SH at 0xFFFFFFFF -> mem_addr sequence 0xFFFFFFFF, 0x00000000.
6. rst asserted during XFER of LW after 2 bytes -> next cycle mem_req=0, stall_req=0 (op=NONE), state IDLE. A subsequent LW completes normally with a fresh buffer.
